// File: rtl/ps2_scanner.sv
// ps2_scanner: PS/2 keyboard deserialiser producing toggle-strobed key events
module ps2_scanner #(
    parameter int TIMEOUT = 12000,
    parameter int FILTER  = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ce,
    input  logic        ps2_kclk,
    input  logic        ps2_kdat,
    output logic [10:0] ps2_key,
    output logic        frame_err
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t            state_q, state_d;
    logic [1:0]        kclk_s_q, kdat_s_q;
    logic [FILTER-1:0] hist_q, hist_d;
    logic              kf_q, kf_d, kprev_q;
    logic [2:0]        cnt_q, cnt_d;
    logic [7:0]        sh_q, sh_d;
    logic              par_q, par_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [2:0]        skip_q, skip_d;
    logic              ext_q, ext_d, rel_q, rel_d;
    logic [10:0]       key_q, key_d;
    logic              err_q, err_d;
    logic              fall, dat, byte_ok, is_resp;

    assign fall      = kprev_q & ~kf_q;
    assign dat       = kdat_s_q[1];
    assign is_resp   = sh_q inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
    assign ps2_key   = key_q;
    assign frame_err = err_q;

    // two-flop synchronisers on both raw lines, clocked regardless of ce
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            kclk_s_q <= 2'b11;
            kdat_s_q <= 2'b11;
        end else begin
            kclk_s_q <= {kclk_s_q[0], ps2_kclk};
            kdat_s_q <= {kdat_s_q[0], ps2_kdat};
        end
    end

    // filtered clock only moves once the whole sample history agrees; lines idle high
    always_comb begin
        hist_d = {hist_q[FILTER-2:0], kclk_s_q[1]};
        kf_d   = (&hist_d) ? 1'b1 : (~|hist_d) ? 1'b0 : kf_q;
    end

    // frame FSM, timeout and prefix decode; the stop-bit fall completes a byte
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        par_d   = par_q;
        tmo_d   = tmo_q;
        skip_d  = skip_q;
        ext_d   = ext_q;
        rel_d   = rel_q;
        key_d   = key_q;
        err_d   = 1'b0;
        byte_ok = 1'b0;
        if (fall) begin
            tmo_d = '0;
            case (state_q)
                IDLE: begin
                    if (!dat) begin
                        state_d = DATA;
                        cnt_d   = 3'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                DATA: begin
                    sh_d    = {dat, sh_q[7:1]};
                    cnt_d   = cnt_q + 3'd1;
                    state_d = (cnt_q == 3'd7) ? PARITY : DATA;
                end
                PARITY: begin
                    par_d   = dat;
                    state_d = STOP;
                end
                default: begin
                    state_d = IDLE;
                    byte_ok = dat & (^{sh_q, par_q});
                    err_d   = ~byte_ok;
                end
            endcase
        end else if (state_q != IDLE) begin
            if (tmo_q == TW'(TIMEOUT - 1)) begin
                state_d = IDLE;
                tmo_d   = '0;
                err_d   = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
        if (byte_ok) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
            end else if (sh_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (sh_q == 8'hF0) begin
                rel_d = 1'b1;
            end else if (sh_q == 8'hE1) begin
                skip_d = 3'd7;
                ext_d  = 1'b0;
                rel_d  = 1'b0;
            end else if (!(is_resp && !ext_q && !rel_q)) begin
                key_d = {~key_q[10], ~rel_q, ext_q, sh_q};
                ext_d = 1'b0;
                rel_d = 1'b0;
            end
        end
    end

    // all protocol state advances on ce-qualified edges only
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            hist_q  <= '1;
            kf_q    <= 1'b1;
            kprev_q <= 1'b1;
            cnt_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            tmo_q   <= '0;
            skip_q  <= '0;
            ext_q   <= 1'b0;
            rel_q   <= 1'b0;
            key_q   <= '0;
            err_q   <= 1'b0;
        end else if (ce) begin
            state_q <= state_d;
            hist_q  <= hist_d;
            kf_q    <= kf_d;
            kprev_q <= kf_q;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            tmo_q   <= tmo_d;
            skip_q  <= skip_d;
            ext_q   <= ext_d;
            rel_q   <= rel_d;
            key_q   <= key_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_ps2_scanner.sv
// tb_ps2_scanner: directed and random PS/2 frames against a byte-level protocol model
module tb_ps2_scanner;
    localparam int TMO  = 300;
    localparam int FILT = 4;
    localparam int HALF = 20;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ce = 1'b1;
    logic        ps2_kclk = 1'b1;
    logic        ps2_kdat = 1'b1;
    logic [10:0] ps2_key;
    logic        frame_err;

    int n_assert = 0;
    int n_fail   = 0;
    int tog      = 0;
    int errs     = 0;
    logic prev_t = 1'b0;

    logic [10:0] m_key  = '0;
    logic        m_ext  = 1'b0;
    logic        m_rel  = 1'b0;
    int          m_skip = 0;
    int          m_tog  = 0;
    int          m_errs = 0;

    logic [7:0] resp [6] = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

    ps2_scanner #(.TIMEOUT(TMO), .FILTER(FILT)) dut (
        .clock(clock),
        .reset(reset),
        .ce(ce),
        .ps2_kclk(ps2_kclk),
        .ps2_kdat(ps2_kdat),
        .ps2_key(ps2_key),
        .frame_err(frame_err)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (!reset) begin
            prev_t = 1'b0;
        end else begin
            if (ps2_key[10] !== prev_t) tog++;
            if (frame_err) errs++;
            prev_t = ps2_key[10];
        end
    end

    task automatic model_byte(input logic [7:0] b);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 6; i++) if (resp[i] == b) r = 1'b1;
        if (m_skip > 0) m_skip--;
        else if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_rel = 1'b1;
        else if (b == 8'hE1) begin
            m_skip = 7;
            m_ext  = 1'b0;
            m_rel  = 1'b0;
        end else if (!(r && !m_ext && !m_rel)) begin
            m_key = {~m_key[10], ~m_rel, m_ext, b};
            m_tog++;
            m_ext = 1'b0;
            m_rel = 1'b0;
        end
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clock);
        ps2_kdat = b;
        repeat (HALF) @(negedge clock);
        ps2_kclk = 1'b0;
        repeat (HALF) @(negedge clock);
        ps2_kclk = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input logic bad_par, input logic bad_stop, input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
        repeat (HALF) @(negedge clock);
    endtask

    task automatic good(input logic [7:0] b);
        send(b, 1'b0, 1'b0, 11);
        model_byte(b);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " key"}, 32'(ps2_key), 32'(m_key));
        check({tag, " toggles"}, tog, m_tog);
        check({tag, " errs"}, errs, m_errs);
    endtask

    initial begin
        repeat (5) @(negedge clock);
        check("reset key", 32'(ps2_key), 32'h000);
        check("reset err", 32'(frame_err), 32'h0);
        reset = 1'b1;
        repeat (10) @(negedge clock);

        good(8'h1C);
        check_all("make 1C");
        check("make 1C value", 32'(ps2_key), 32'h61C);
        good(8'hF0);
        good(8'h1C);
        check_all("break 1C");

        good(8'hE0);
        check_all("prefix E0 alone");
        good(8'h75);
        check_all("ext make 75");
        good(8'hE0);
        good(8'hF0);
        good(8'h75);
        check_all("ext break 75");

        send(8'h16, 1'b1, 1'b0, 11);
        m_errs++;
        check_all("parity err");
        good(8'h16);
        check_all("after parity 16");

        ps2_bit(1'b1);
        repeat (HALF) @(negedge clock);
        m_errs++;
        check_all("bad start");

        send(8'h3C, 1'b0, 1'b1, 11);
        m_errs++;
        check_all("bad stop");

        send(8'h29, 1'b0, 1'b0, 5);
        repeat (TMO - 2 * HALF - 20) @(negedge clock);
        check_all("before timeout");
        repeat (60) @(negedge clock);
        m_errs++;
        check_all("timeout");
        good(8'h29);
        check_all("after timeout 29");

        good(8'hE1);
        good(8'h14);
        good(8'h77);
        good(8'hE1);
        good(8'hF0);
        good(8'h14);
        good(8'hF0);
        good(8'h77);
        check_all("pause");
        good(8'hAA);
        check_all("device resp");
        good(8'h5A);
        check_all("after pause 5A");

        @(negedge clock);
        ps2_kclk = 1'b0;
        repeat (2) @(negedge clock);
        ps2_kclk = 1'b1;
        repeat (40) @(negedge clock);
        check_all("glitch");

        good(8'hE0);
        send(8'h1C, 1'b0, 1'b0, 3);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        check("mid reset key", 32'(ps2_key), 32'h000);
        check("mid reset err", 32'(frame_err), 32'h0);
        m_key  = '0;
        m_ext  = 1'b0;
        m_rel  = 1'b0;
        m_skip = 0;
        reset = 1'b1;
        repeat (10) @(negedge clock);
        good(8'h1C);
        check_all("after reset 1C");

        for (int k = 0; k < 24; k++) begin
            logic [7:0] b;
            int r;
            r = int'($urandom_range(0, 9));
            b = (r < 2) ? 8'hE0 : (r == 2) ? 8'hF0 : (r == 3) ? resp[$urandom_range(0, 5)] : 8'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                send(b, 1'b1, $urandom_range(0, 1) == 1, 11);
                m_errs++;
            end else begin
                good(b);
            end
            check_all("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
